// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//
// Multi-digit BCD up/down counter with synchronous clear, validated parallel
// load, optional saturation at terminal count, and a combinational
// terminal-count output for cascading.
//
// Parameters
//   DIGITS   : number of BCD digits (1..8)
//   SATURATE : 0 = wrap at terminal count, 1 = hold at terminal count
//
// Ports
//   clk       in   rising-edge clock for all state
//   reset     in   asynchronous, active-high reset (count/ovf/load_err -> 0)
//   clear     in   synchronous clear to zero (highest priority)
//   load      in   synchronous parallel load request
//   load_val  in   BCD load value, digit 0 in bits [3:0]
//   en        in   count enable, one decimal step per enabled edge
//   up        in   direction, 1 = increment, 0 = decrement
//   count     out  registered BCD count, digit 0 least significant
//   tc        out  combinational terminal count / cascade carry
//   ovf       out  registered one-cycle pulse after a step taken at terminal
//   load_err  out  registered one-cycle pulse after a load with a non-BCD digit
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]      count_q;
    logic [W-1:0]      count_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              load_err_q;
    logic              load_err_d;

    logic [W-1:0]      count_step;
    logic [DIGITS-1:0] digit_nine;
    logic [DIGITS-1:0] digit_zero;
    logic [DIGITS-1:0] load_digit_bad;
    logic [DIGITS-1:0] inc_carry;
    logic [DIGITS-1:0] dec_borrow;
    logic              all_nine;
    logic              all_zero;
    logic              at_terminal;

    // Per-digit decode and stepping. A digit moves only when every lower
    // digit sits at its rollover value (9 going up, 0 going down).
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] cur;
            logic [3:0] ld;
            logic [3:0] inc_val;
            logic [3:0] dec_val;

            assign cur                 = count_q[4*gi +: 4];
            assign ld                  = load_val[4*gi +: 4];
            assign digit_nine[gi]      = (cur == 4'd9);
            assign digit_zero[gi]      = (cur == 4'd0);
            assign load_digit_bad[gi]  = (ld > 4'd9);
            assign inc_val             = digit_nine[gi] ? 4'd0 : (cur + 4'd1);
            assign dec_val             = digit_zero[gi] ? 4'd9 : (cur - 4'd1);
            assign count_step[4*gi +: 4] =
                up ? (inc_carry[gi]  ? inc_val : cur)
                   : (dec_borrow[gi] ? dec_val : cur);
        end
    endgenerate

    // Carry/borrow chains kept inside one process so the ripple is a plain
    // combinational loop over digits rather than a self-referencing vector.
    always_comb begin
        inc_carry     = '0;
        dec_borrow    = '0;
        inc_carry[0]  = 1'b1;
        dec_borrow[0] = 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
            inc_carry[i]  = inc_carry[i-1]  & digit_nine[i-1];
            dec_borrow[i] = dec_borrow[i-1] & digit_zero[i-1];
        end
    end

    assign all_nine    = &digit_nine;
    assign all_zero    = &digit_zero;
    assign at_terminal = up ? all_nine : all_zero;

    // Cascade carry is deliberately not gated by clear/load so that a chain
    // of counters sees a stable carry purely from count, en and up.
    assign tc = en & at_terminal;

    // Next-state: clear > load > en.
    always_comb begin
        count_d    = count_q;
        ovf_d      = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            if (|load_digit_bad) begin
                load_err_d = 1'b1;
            end else begin
                count_d = load_val;
            end
        end else if (en) begin
            ovf_d = at_terminal;
            // The stepped value already wraps 9..9 <-> 0..0; saturation just
            // suppresses that step at terminal count.
            if (!(SATURATE && at_terminal)) begin
                count_d = count_step;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign ovf      = ovf_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Drives two counters with identical control inputs:
//   u_wrap : DIGITS=4, SATURATE=0
//   u_sat  : DIGITS=2, SATURATE=1 (sees load_val[7:0])
// A decimal-integer reference model produces expected values that are pushed
// into a scoreboard queue at drive time and popped after the clock edge.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic [15:0] load_val4 = '0;
    logic [7:0]  load_val2 = '0;

    logic [15:0] count4;
    logic        tc4, ovf4, lerr4;
    logic [7:0]  count2;
    logic        tc2, ovf2, lerr2;

    bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_val(load_val4), .en(en), .up(up),
        .count(count4), .tc(tc4), .ovf(ovf4), .load_err(lerr4)
    );

    bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_val(load_val2), .en(en), .up(up),
        .count(count2), .tc(tc2), .ovf(ovf2), .load_err(lerr2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] c4;
        logic        o4;
        logic        e4;
        logic [7:0]  c2;
        logic        o2;
        logic        e2;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m4 = 0;      // reference count, decimal, wrapping instance
    int   m2 = 0;      // reference count, decimal, saturating instance
    bit   quiet = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [15:0] b, input int digits);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < digits; i++)
            if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic int from_bcd(input logic [15:0] b, input int digits);
        int r;
        r = 0;
        for (int i = digits - 1; i >= 0; i--)
            r = r * 10 + int'(b[4*i +: 4]);
        return r;
    endfunction

    function automatic void model(inout int m, input int maxv, input bit sat,
                                  input int digits, input bit c, input bit l,
                                  input bit e, input bit u, input logic [15:0] lv,
                                  output bit o, output bit le);
        o  = 1'b0;
        le = 1'b0;
        if (c) begin
            m = 0;
        end else if (l) begin
            if (bcd_ok(lv, digits)) m = from_bcd(lv, digits);
            else le = 1'b1;
        end else if (e) begin
            if (u) begin
                if (m == maxv) begin
                    o = 1'b1;
                    if (!sat) m = 0;
                end else m = m + 1;
            end else begin
                if (m == 0) begin
                    o = 1'b1;
                    if (!sat) m = maxv;
                end else m = m - 1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One transaction: drive at negedge, check tc before the edge, score the
    // registered outputs just after the edge.
    task automatic step(input string tag, input bit c, input bit l, input bit e,
                        input bit u, input logic [15:0] lv);
        exp_t x;
        bit   o, le;
        @(negedge clk);
        clear = c; load = l; en = e; up = u;
        load_val4 = lv; load_val2 = lv[7:0];
        #1;
        chk({tag, ".tc4"}, 32'(tc4), 32'(e && (u ? (m4 == 9999) : (m4 == 0))));
        chk({tag, ".tc2"}, 32'(tc2), 32'(e && (u ? (m2 == 99) : (m2 == 0))));
        x.tag = tag;
        model(m4, 9999, 1'b0, 4, c, l, e, u, lv, o, le);
        x.c4 = to_bcd(m4); x.o4 = o; x.e4 = le;
        model(m2, 99, 1'b1, 2, c, l, e, u, lv, o, le);
        x.c2 = to_bcd(m2)[7:0]; x.o2 = o; x.e2 = le;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({x.tag, ".count4"}, 32'(count4), 32'(x.c4));
        chk({x.tag, ".ovf4"},   32'(ovf4),   32'(x.o4));
        chk({x.tag, ".lerr4"},  32'(lerr4),  32'(x.e4));
        chk({x.tag, ".count2"}, 32'(count2), 32'(x.c2));
        chk({x.tag, ".ovf2"},   32'(ovf2),   32'(x.o2));
        chk({x.tag, ".lerr2"},  32'(lerr2),  32'(x.e2));
        if (!quiet)
            $display("txn %-10s clr=%0b ld=%0b en=%0b up=%0b lv=%h -> c4=%h o4=%0b e4=%0b c2=%h o2=%0b e2=%0b",
                     x.tag, c, l, e, u, lv, count4, ovf4, lerr4, count2, ovf2, lerr2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Asynchronous reset with en=1, up=0: tc must show the all-zero terminal.
        en = 1'b1; up = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst.count4", 32'(count4), 32'h0);
        chk("rst.ovf4",   32'(ovf4),   32'h0);
        chk("rst.lerr4",  32'(lerr4),  32'h0);
        chk("rst.count2", 32'(count2), 32'h0);
        chk("rst.tc4",    32'(tc4),    32'h1);
        chk("rst.tc2",    32'(tc2),    32'h1);
        repeat (2) @(posedge clk);
        #1;
        chk("rsthold.count4", 32'(count4), 32'h0);
        chk("rsthold.ovf4",   32'(ovf4),   32'h0);
        @(negedge clk);
        en = 1'b0;
        reset = 1'b0;
        m4 = 0; m2 = 0;
        $display("txn reset      released");

        // Full up-count: 9999 at clock 9999, wrap with ovf at clock 10000.
        quiet = 1'b1;
        for (int i = 1; i <= 10000; i++) step("upsweep", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        quiet = 1'b0;
        $display("txn upsweep    10000 steps c4=%h o4=%0b", count4, ovf4);
        step("idle", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

        // Down-count through digit borrow, then wrap from zero.
        step("ld0010",  1'b0, 1'b1, 1'b0, 1'b0, 16'h0010);
        step("dn1",     1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        step("dn2",     1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        step("ld0000",  1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step("dnwrap",  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        step("dnafter", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        step("ld1000",  1'b0, 1'b1, 1'b0, 1'b0, 16'h1000);
        step("dnborrow",1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);

        // Saturating instance held at 99 while stepping up.
        step("ld0099",  1'b0, 1'b1, 1'b0, 1'b1, 16'h0099);
        step("sat1",    1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        step("sat2",    1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        step("sat3",    1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);

        // Illegal loads leave count and pulse load_err for one cycle.
        step("ld01A3",  1'b0, 1'b1, 1'b0, 1'b0, 16'h01A3);
        step("errgone", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step("ld0123",  1'b0, 1'b1, 1'b0, 1'b0, 16'h0123);
        step("ldF000",  1'b0, 1'b1, 1'b0, 1'b0, 16'hF000);

        // Priority: clear > load > en.
        step("ld0045",  1'b0, 1'b1, 1'b0, 1'b1, 16'h0045);
        step("clrall",  1'b1, 1'b1, 1'b1, 1'b1, 16'h0045);
        step("ldEn777", 1'b0, 1'b1, 1'b1, 1'b1, 16'h0777);
        step("ld9999",  1'b0, 1'b1, 1'b0, 1'b1, 16'h9999);
        step("clrAtTc", 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);

        // Direction changes on consecutive cycles.
        step("ld0009",  1'b0, 1'b1, 1'b0, 1'b1, 16'h0009);
        step("dirUp",   1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        step("dirDn",   1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        step("dirDn2",  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);

        // Count to 0037, then reset asynchronously between edges.
        step("clr",     1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        quiet = 1'b1;
        for (int i = 0; i < 37; i++) step("to37", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        quiet = 1'b0;
        chk("at37.count4", 32'(count4), 32'h0037);
        @(negedge clk);
        en = 1'b0; clear = 1'b0; load = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst.count4", 32'(count4), 32'h0);
        chk("arst.count2", 32'(count2), 32'h0);
        chk("arst.ovf4",   32'(ovf4),   32'h0);
        #1 reset = 1'b0;
        m4 = 0; m2 = 0;
        $display("txn arst       c4=%h c2=%h", count4, count2);
        step("restart", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        step("restart2",1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);

        chk("sb.empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits; legal range 1..8.
REQ-002 SHALL have parameter SATURATE, default 0, 0 = wrap at terminal count, 1 = hold at terminal count.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous clear to zero.
REQ-006 SHALL have port load  input  1  synchronous parallel load request.
REQ-007 SHALL have port load_val  input  4*DIGITS  BCD load value, digit 0 in bits [3:0].
REQ-008 SHALL have port en  input  1  count enable, one step per enabled clock.
REQ-009 SHALL have port up  input  1  direction, 1 = increment, 0 = decrement.
REQ-010 SHALL have port count  output  4*DIGITS  registered BCD count, digit 0 least significant.
REQ-011 SHALL have port tc  output  1  combinational terminal-count / cascade carry.
REQ-012 SHALL have port ovf  output  1  registered one-cycle wrap/saturation event pulse.
REQ-013 SHALL have port load_err  output  1  registered one-cycle illegal-load pulse.

Function
REQ-014 SHALL be fully synchronous to clk except reset; no derived or ripple clocks.
REQ-015 SHALL apply per-edge priority: clear > load > en; lower-priority requests in the same cycle are ignored.
REQ-016 SHALL, on clear, set count to all zero on the same edge, regardless of load/en.
REQ-017 SHALL, on load with every load_val digit in 0..9, set count to load_val on the same edge.
REQ-018 SHALL, on load with any load_val digit in 10..15, leave count unchanged and pulse load_err high for exactly the following cycle.
REQ-019 SHALL, with en=1 and no clear/load, step count by exactly one decimal unit per edge, latency one clock.
REQ-020 SHALL increment digit i when up=1 and digits 0..i-1 all equal 9; digit at 9 becomes 0, else +1.
REQ-021 SHALL decrement digit i when up=0 and digits 0..i-1 all equal 0; digit at 0 becomes 9, else -1.
REQ-022 SHALL never hold any digit of count outside 0..9.
REQ-023 SHALL drive tc = en AND ((up AND all digits 9) OR (NOT up AND all digits 0)), no gating by clear/load.
REQ-024 SHALL, with SATURATE=0, wrap all-9 -> all-0 (up) and all-0 -> all-9 (down) on an enabled terminal step.
REQ-025 SHALL, with SATURATE=1, hold count unchanged on an enabled step at terminal count.
REQ-026 SHALL pulse ovf high for the one cycle after any enabled step taken at terminal count (either SATURATE mode); ovf low when clear or load wins that edge.
REQ-027 SHALL honour a direction change on any cycle; up is sampled on the same edge as en.
REQ-028 SHALL hold count, ovf=0, load_err=0 when en=0, load=0, clear=0.

Reset
REQ-029 SHALL, while reset=1, force count=0, ovf=0, load_err=0 immediately, independent of clk.
REQ-030 SHALL, on reset deassertion, resume on the first rising clk edge with count=0; reset asserted mid-count discards the count.
REQ-031 SHALL drive tc during reset per REQ-023 (tc=1 when en=1 and up=0).

Verification
REQ-032 SHALL cover: DIGITS=4, reset, en=1 up=1 for 10000 clocks -> count reaches 9999 at clock 9999, wraps to 0000 with ovf one cycle, tc high only at 9999.
REQ-033 SHALL cover: DIGITS=2, load 0x10 then en=1 up=0 -> 09, 08; load 0x00, step down -> 99, ovf pulse.
REQ-034 SHALL cover: SATURATE=1, DIGITS=2, load 0x99, en=1 up=1 for 3 clocks -> count stays 99, ovf high each following cycle.
REQ-035 SHALL cover: load 0x1A3 (DIGITS=3) -> count unchanged, load_err one cycle; load 0x123 -> count 123.
REQ-036 SHALL cover: clear, load, en all high with count 0045 -> count 0000, ovf=0; load+en with 0x0777 -> 0777, not 0778.
REQ-037 SHALL cover: reset pulsed asynchronously between edges at count 0037 -> count 0000 before next edge, counting restarts from 0001.
